// File: rtl/updown_counter.sv
// updown_counter: clocked up/down event counter with modulus, wrap/saturate
// modes, synchronous clear/load, carry/borrow pulses and sticky flags.
module updown_counter #(
    parameter int     SIZE        = 8,
    parameter longint MODULUS     = 256,
    parameter bit     SATURATE    = 1'b0,
    parameter bit     EDGE_DETECT = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            load,
    input  logic [SIZE-1:0] load_value,
    input  logic            up,
    input  logic            down,
    output logic [SIZE-1:0] value,
    output logic            carry,
    output logic            borrow,
    output logic            overflow,
    output logic            underflow,
    output logic            at_max,
    output logic            at_zero
);

    // Top of the count range. MODULUS-1 always fits in SIZE bits, so this
    // never needs a wider compare, even when MODULUS == 2^SIZE.
    localparam logic [SIZE-1:0] MAX_V = SIZE'(MODULUS - 1);
    localparam logic [SIZE-1:0] ONE   = SIZE'(1);

    generate
        if (MODULUS < 2 || MODULUS > (longint'(1) << SIZE)) begin : g_bad_modulus
            $fatal(1, "updown_counter: MODULUS out of range 2..2^SIZE");
        end
    endgenerate

    logic            r_up_q;
    logic            r_down_q;
    logic [SIZE-1:0] r_value;
    logic            r_carry;
    logic            r_borrow;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_inc;
    logic            w_dec;
    logic            w_at_max;
    logic            w_at_zero;
    logic [SIZE-1:0] w_load_val;

    // Events: rising edge of up/down, or plain level when edge detection is off.
    // A load value above the range clamps to the top; comparing against MAX_V
    // instead of MODULUS keeps everything in SIZE bits.
    always_comb begin
        w_inc      = EDGE_DETECT ? (up & ~r_up_q) : up;
        w_dec      = EDGE_DETECT ? (down & ~r_down_q) : down;
        w_at_max   = (r_value == MAX_V);
        w_at_zero  = (r_value == '0);
        w_load_val = (load_value > MAX_V) ? MAX_V : load_value;
    end

    // Edge history; resets low so an up held across reset release counts once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_up_q   <= 1'b0;
            r_down_q <= 1'b0;
        end else begin
            r_up_q   <= up;
            r_down_q <= down;
        end
    end

    // Count state: clear beats load beats count; inc and dec together cancel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value     <= '0;
            r_carry     <= 1'b0;
            r_borrow    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            if (clear) begin
                r_value     <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else if (load) begin
                r_value <= w_load_val;
            end else if (w_inc && !w_dec) begin
                if (w_at_max) begin
                    r_carry    <= 1'b1;
                    r_overflow <= 1'b1;
                    if (!SATURATE) r_value <= '0;
                end else begin
                    r_value <= r_value + ONE;
                end
            end else if (w_dec && !w_inc) begin
                if (w_at_zero) begin
                    r_borrow    <= 1'b1;
                    r_underflow <= 1'b1;
                    if (!SATURATE) r_value <= MAX_V;
                end else begin
                    r_value <= r_value - ONE;
                end
            end
        end
    end

    assign value     = r_value;
    assign carry     = r_carry;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign at_max    = w_at_max;
    assign at_zero   = w_at_zero;

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed bench over three configurations:
//   [0] MODULUS=10 wrap, edge mode; [1] MODULUS=10 saturate, edge mode;
//   [2] MODULUS=256 wrap, level mode.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear [3];
    logic       load  [3];
    logic [7:0] lv    [3];
    logic       up    [3];
    logic       down  [3];
    logic [7:0] val   [3];
    logic       cy    [3];
    logic       bw    [3];
    logic       ovf   [3];
    logic       unf   [3];
    logic       amax  [3];
    logic       azero [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    updown_counter #(.SIZE(8), .MODULUS(10), .SATURATE(1'b0), .EDGE_DETECT(1'b1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear[0]), .load(load[0]), .load_value(lv[0]),
        .up(up[0]), .down(down[0]), .value(val[0]), .carry(cy[0]), .borrow(bw[0]),
        .overflow(ovf[0]), .underflow(unf[0]), .at_max(amax[0]), .at_zero(azero[0]));

    updown_counter #(.SIZE(8), .MODULUS(10), .SATURATE(1'b1), .EDGE_DETECT(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear[1]), .load(load[1]), .load_value(lv[1]),
        .up(up[1]), .down(down[1]), .value(val[1]), .carry(cy[1]), .borrow(bw[1]),
        .overflow(ovf[1]), .underflow(unf[1]), .at_max(amax[1]), .at_zero(azero[1]));

    updown_counter #(.SIZE(8), .MODULUS(256), .SATURATE(1'b0), .EDGE_DETECT(1'b0)) u_lvl (
        .clk(clk), .reset_n(reset_n), .clear(clear[2]), .load(load[2]), .load_value(lv[2]),
        .up(up[2]), .down(down[2]), .value(val[2]), .carry(cy[2]), .borrow(bw[2]),
        .overflow(ovf[2]), .underflow(unf[2]), .at_max(amax[2]), .at_zero(azero[2]));

    // Advance past the next rising edge; outputs are stable 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full edge on instance k: up high for one clock, then low for one clock.
    task automatic up_edge(input int k);
        up[k] = 1'b1; tick();
        up[k] = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clear[k] = 0; load[k] = 0; lv[k] = 0; up[k] = 0; down[k] = 0;
        end
        up[0] = 1'b1;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({val[k], cy[k], bw[k], ovf[k], unf[k], azero[k]} !== {8'd0, 5'b00001}) begin
                failures++;
                $display("FAIL reset_state[%0d] got val=%0d c=%b b=%b o=%b u=%b z=%b exp val=0 flags 0 z=1",
                         k, val[k], cy[k], bw[k], ovf[k], unf[k], azero[k]);
            end
        end
        // Release between edges while up[0] is still high.
        #2 reset_n = 1'b1;
        tick();
        checks++;
        if (val[0] !== 8'd1 || cy[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_edge_first got val=%0d c=%b exp val=1 c=0", val[0], cy[0]);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (val[0] !== 8'd1 || cy[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_edge_hold got val=%0d c=%b exp val=1 c=0", val[0], cy[0]);
        end
    endtask

    task automatic test_wrap();
        int ncarry;
        up[0] = 1'b0; clear[0] = 1'b1; tick(); clear[0] = 1'b0;
        ncarry = 0;
        for (int i = 1; i <= 10; i++) begin
            up[0] = 1'b1; tick();
            if (cy[0]) ncarry++;
            checks++;
            if (val[0] !== 8'(i % 10) || cy[0] !== (i == 10)) begin
                failures++;
                $display("FAIL wrap_step%0d got val=%0d c=%b exp val=%0d c=%b", i, val[0], cy[0], i % 10, i == 10);
            end
            up[0] = 1'b0; tick();
            if (cy[0]) ncarry++;
        end
        checks++;
        if (ncarry !== 1 || ovf[0] !== 1'b1 || azero[0] !== 1'b1 || val[0] !== 8'd0) begin
            failures++;
            $display("FAIL wrap_end got carries=%0d o=%b z=%b val=%0d exp carries=1 o=1 z=1 val=0",
                     ncarry, ovf[0], azero[0], val[0]);
        end
        down[0] = 1'b1; tick();
        checks++;
        if (val[0] !== 8'd9 || bw[0] !== 1'b1 || unf[0] !== 1'b1 || amax[0] !== 1'b1 || cy[0] !== 1'b0) begin
            failures++;
            $display("FAIL wrap_borrow got val=%0d b=%b u=%b m=%b c=%b exp val=9 b=1 u=1 m=1 c=0",
                     val[0], bw[0], unf[0], amax[0], cy[0]);
        end
        down[0] = 1'b0; tick();
        checks++;
        if (bw[0] !== 1'b0 || val[0] !== 8'd9 || unf[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_borrow_pulse got b=%b val=%0d u=%b exp b=0 val=9 u=1", bw[0], val[0], unf[0]);
        end
    endtask

    task automatic test_saturate();
        load[1] = 1'b1; lv[1] = 8'd9; tick(); load[1] = 1'b0;
        checks++;
        if (val[1] !== 8'd9 || ovf[1] !== 1'b0) begin
            failures++;
            $display("FAIL sat_load9 got val=%0d o=%b exp val=9 o=0", val[1], ovf[1]);
        end
        for (int i = 1; i <= 3; i++) begin
            up[1] = 1'b1; tick();
            checks++;
            if (val[1] !== 8'd9 || cy[1] !== 1'b1 || ovf[1] !== 1'b1) begin
                failures++;
                $display("FAIL sat_up%0d got val=%0d c=%b o=%b exp val=9 c=1 o=1", i, val[1], cy[1], ovf[1]);
            end
            up[1] = 1'b0; tick();
        end
        load[1] = 1'b1; lv[1] = 8'd0; tick(); load[1] = 1'b0;
        down[1] = 1'b1; tick();
        checks++;
        if (val[1] !== 8'd0 || bw[1] !== 1'b1 || unf[1] !== 1'b1 || ovf[1] !== 1'b1) begin
            failures++;
            $display("FAIL sat_down got val=%0d b=%b u=%b o=%b exp val=0 b=1 u=1 o=1", val[1], bw[1], unf[1], ovf[1]);
        end
        down[1] = 1'b0; tick();
    endtask

    task automatic test_priority();
        // u_wrap holds 9 with both sticky flags set.
        clear[0] = 1'b1; load[0] = 1'b1; lv[0] = 8'd5; up[0] = 1'b1; tick();
        checks++;
        if (val[0] !== 8'd0 || ovf[0] !== 1'b0 || unf[0] !== 1'b0 || cy[0] !== 1'b0) begin
            failures++;
            $display("FAIL prio_clear got val=%0d o=%b u=%b c=%b exp val=0 flags 0", val[0], ovf[0], unf[0], cy[0]);
        end
        clear[0] = 1'b0; lv[0] = 8'd200; up[0] = 1'b0; tick();
        checks++;
        if (val[0] !== 8'd9) begin
            failures++;
            $display("FAIL prio_load_clamp got val=%0d exp 9", val[0]);
        end
        lv[0] = 8'd3; up[0] = 1'b1; tick();
        checks++;
        if (val[0] !== 8'd3) begin
            failures++;
            $display("FAIL prio_load_over_inc got val=%0d exp 3", val[0]);
        end
        load[0] = 1'b0; up[0] = 1'b0; tick();
        load[0] = 1'b1; lv[0] = 8'd9; tick(); load[0] = 1'b0;
        up[0] = 1'b1; down[0] = 1'b1; tick();
        checks++;
        if (val[0] !== 8'd9 || cy[0] !== 1'b0 || bw[0] !== 1'b0 || ovf[0] !== 1'b0 || unf[0] !== 1'b0) begin
            failures++;
            $display("FAIL prio_cancel got val=%0d c=%b b=%b o=%b u=%b exp val=9 all 0",
                     val[0], cy[0], bw[0], ovf[0], unf[0]);
        end
        up[0] = 1'b0; down[0] = 1'b0; tick();
    endtask

    task automatic test_level();
        int ncarry;
        int carry_at;
        ncarry = 0; carry_at = -1;
        up[2] = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (cy[2]) begin ncarry++; carry_at = i; end
        end
        up[2] = 1'b0;
        checks++;
        if (val[2] !== 8'd44 || ncarry !== 1 || carry_at !== 256 || ovf[2] !== 1'b1) begin
            failures++;
            $display("FAIL level_count got val=%0d carries=%0d at=%0d o=%b exp val=44 carries=1 at=256 o=1",
                     val[2], ncarry, carry_at, ovf[2]);
        end
        tick(); tick(); tick();
        checks++;
        if (ovf[2] !== 1'b1 || val[2] !== 8'd44) begin
            failures++;
            $display("FAIL level_sticky got o=%b val=%0d exp o=1 val=44", ovf[2], val[2]);
        end
        clear[2] = 1'b1; tick(); clear[2] = 1'b0;
        checks++;
        if (ovf[2] !== 1'b0 || val[2] !== 8'd0) begin
            failures++;
            $display("FAIL level_clear got o=%b val=%0d exp o=0 val=0", ovf[2], val[2]);
        end
    endtask

    task automatic test_async_reset();
        // 9 -> 0 sets overflow, then 7 more edges reach 7.
        load[0] = 1'b1; lv[0] = 8'd9; tick(); load[0] = 1'b0;
        for (int i = 0; i < 8; i++) up_edge(0);
        checks++;
        if (val[0] !== 8'd7 || ovf[0] !== 1'b1) begin
            failures++;
            $display("FAIL async_setup got val=%0d o=%b exp val=7 o=1", val[0], ovf[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (val[0] !== 8'd0 || ovf[0] !== 1'b0 || unf[0] !== 1'b0 || azero[0] !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got val=%0d o=%b u=%b z=%b exp val=0 o=0 u=0 z=1",
                     val[0], ovf[0], unf[0], azero[0]);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (val[0] !== 8'd0) begin
            failures++;
            $display("FAIL async_after got val=%0d exp 0", val[0]);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_priority();
        test_level();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
